// File: rtl/pe_cpa_if.sv
// Data bundle for one carry-save systolic PE: activation, weight and partial-sum lanes.
// master drives the PE inputs; slave is the PE itself.
interface pe_cpa_if #(
    parameter int SIZE = 4
);
    localparam int W = SIZE + 16;

    logic         preclk;
    logic [7:0]   weight;
    logic [7:0]   in;
    logic [W-1:0] psum0;
    logic [W-1:0] psum1;
    logic [7:0]   weightO;
    logic [7:0]   inO;
    logic [W-1:0] psumO0;
    logic [W-1:0] psumO1;
    logic [W:0]   out;
    logic [W-1:0] finalout;

    modport master (
        output preclk, weight, in, psum0, psum1,
        input  weightO, inO, psumO0, psumO1, out, finalout
    );

    modport slave (
        input  preclk, weight, in, psum0, psum1,
        output weightO, inO, psumO0, psumO1, out, finalout
    );
endinterface

// File: rtl/pe_cpa.sv
// Systolic PE: stored signed weight times activation, accumulated in carry-save form,
// with a carry-propagate output adder. Define PE_CPA_OUTREG_EN to register out/finalout.
module pe_cpa #(
    parameter int SIZE = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pe_cpa_if.slave   bus
);
    localparam int W = SIZE + 16;

    logic [7:0]   r_weight;
    logic [7:0]   r_in;
    logic [W-1:0] r_psum0;
    logic [W-1:0] r_psum1;

    logic [15:0]  w_weight16;
    logic [15:0]  w_in16;
    logic [15:0]  w_prod16;
    logic [W-1:0] w_prod;
    logic [W-1:0] w_s;
    logic [W-1:0] w_maj;
    logic [W-1:0] w_c;
    logic [W:0]   w_sum;

    // The low 16 bits of a 16x16 product of sign-extended operands equal the signed 8x8 product.
    assign w_weight16 = {{8{r_weight[7]}}, r_weight};
    assign w_in16     = {{8{bus.in[7]}}, bus.in};
    assign w_prod16   = w_weight16 * w_in16;
    assign w_prod     = {{SIZE{w_prod16[15]}}, w_prod16};

    assign w_s   = bus.psum0 ^ bus.psum1 ^ w_prod;
    assign w_maj = (bus.psum0 & bus.psum1) | (bus.psum0 & w_prod) | (bus.psum1 & w_prod);
    assign w_c   = {w_maj[W-2:0], 1'b0};

    // Product uses the weight held before this edge, so a same-cycle load applies next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight <= '0;
            r_in     <= '0;
            r_psum0  <= '0;
            r_psum1  <= '0;
        end else begin
            if (bus.preclk) begin
                r_weight <= bus.weight;
            end
            r_in    <= bus.in;
            r_psum0 <= w_s;
            r_psum1 <= w_c;
        end
    end

    assign w_sum = {1'b0, r_psum0} + {1'b0, r_psum1};

    assign bus.weightO = r_weight;
    assign bus.inO     = r_in;
    assign bus.psumO0  = r_psum0;
    assign bus.psumO1  = r_psum1;

`ifdef PE_CPA_OUTREG_EN
    logic [W:0] r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_sum;
        end
    end

    assign bus.out      = r_out;
    assign bus.finalout = r_out[W-1:0];
`else
    assign bus.out      = w_sum;
    assign bus.finalout = w_sum[W-1:0];
`endif

endmodule

// File: tb/tb_pe_cpa.sv
// Self-checking bench for pe_cpa: directed corner cases then a randomized stream
// compared against an arithmetic reference (weight*in + psum0 + psum1 mod 2^W).
module tb_pe_cpa;
    localparam int SIZE = 4;
    localparam int W    = SIZE + 16;
`ifdef PE_CPA_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NRAND = 100;

    logic clk;
    logic rst_n;

    pe_cpa_if #(.SIZE(SIZE)) bus ();

    pe_cpa #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pre, input logic [7:0] w, input logic [7:0] a,
                         input logic [W-1:0] p0, input logic [W-1:0] p1);
        bus.preclk = pre;
        bus.weight = w;
        bus.in     = a;
        bus.psum0  = p0;
        bus.psum1  = p1;
    endtask

    function automatic logic [W-1:0] ref_sum(input logic [7:0] w, input logic [7:0] a,
                                             input logic [W-1:0] p0, input logic [W-1:0] p1);
        longint prod;
        longint total;
        prod  = longint'($signed(w)) * longint'($signed(a));
        total = prod + longint'(p0) + longint'(p1);
        return W'(total);
    endfunction

    logic [7:0]   m_w;
    logic [W-1:0] exp_arr [NRAND];
    logic [7:0]   in_arr  [NRAND];

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, '0, '0);
        #12;
        chk("reset_weightO",  32'(bus.weightO),  32'h0);
        chk("reset_inO",      32'(bus.inO),      32'h0);
        chk("reset_psumO0",   32'(bus.psumO0),   32'h0);
        chk("reset_psumO1",   32'(bus.psumO1),   32'h0);
        chk("reset_out",      32'(bus.out),      32'h0);
        chk("reset_finalout", 32'(bus.finalout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // weight 3, in 5, psum0 10 -> 25
        drive(1'b1, 8'd3, 8'd0, '0, '0);
        tick();
        chk("load3_weightO", 32'(bus.weightO), 32'd3);
        drive(1'b0, 8'd3, 8'd5, W'(10), '0);
        repeat (LAT) tick();
        chk("w3_finalout", 32'(bus.finalout), 32'd25);
        chk("w3_inO",      32'(bus.inO),      32'd5);
        chk("w3_weightO",  32'(bus.weightO),  32'd3);

        // weight -2, in 7 -> -14
        drive(1'b1, 8'hFE, 8'd0, '0, '0);
        tick();
        drive(1'b0, 8'hFE, 8'd7, '0, '0);
        repeat (LAT) tick();
        chk("neg_finalout", 32'(bus.finalout), 32'h000F_FFF2);
        chk("neg_out",      32'(bus.out),      32'h000F_FFF2);

        // signed wrap at 2^(W-1)
        drive(1'b1, 8'h00, 8'd0, '0, '0);
        tick();
        drive(1'b0, 8'h00, 8'h55, W'(20'h7FFFF), W'(1));
        repeat (LAT) tick();
        chk("wrap_out",      32'(bus.out),      32'h0008_0000);
        chk("wrap_finalout", 32'(bus.finalout), 32'h0008_0000);

        // weight input changes to 9 with preclk low: stored 5 must be kept
        drive(1'b1, 8'd5, 8'd0, '0, '0);
        tick();
        drive(1'b0, 8'd9, 8'd4, '0, '0);
        repeat (LAT) tick();
        chk("hold_weightO",  32'(bus.weightO),  32'd5);
        chk("hold_finalout", 32'(bus.finalout), 32'd20);

        // same-cycle load: first product uses old weight 5, next uses 9
        drive(1'b1, 8'd9, 8'd2, '0, '0);
        tick();
        drive(1'b0, 8'd9, 8'd2, '0, '0);
        repeat (LAT - 1) tick();
        chk("sameload_old", 32'(bus.finalout), 32'd10);
        tick();
        chk("sameload_new", 32'(bus.finalout), 32'd18);
        chk("sameload_wO",  32'(bus.weightO),  32'd9);

        // asynchronous reset mid-stream
        drive(1'b0, 8'd9, 8'd33, W'(123), W'(77));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_weightO",  32'(bus.weightO),  32'h0);
        chk("arst_inO",      32'(bus.inO),      32'h0);
        chk("arst_psumO0",   32'(bus.psumO0),   32'h0);
        chk("arst_psumO1",   32'(bus.psumO1),   32'h0);
        chk("arst_finalout", 32'(bus.finalout), 32'h0);
        #1;
        rst_n = 1'b1;
        // weight is 0 after reset until reloaded
        drive(1'b0, 8'd9, 8'd7, W'(3), '0);
        repeat (LAT) tick();
        chk("post_rst_finalout", 32'(bus.finalout), 32'd3);

        // randomized stream with occasional weight reloads
        m_w = 8'($urandom);
        drive(1'b1, m_w, 8'd0, '0, '0);
        tick();
        for (int j = 0; j < NRAND + LAT; j++) begin
            if (j >= LAT) chk($sformatf("rand_finalout[%0d]", j - LAT), 32'(bus.finalout), 32'(exp_arr[j - LAT]));
            if (j >= 1 && j <= NRAND) chk($sformatf("rand_inO[%0d]", j - 1), 32'(bus.inO), 32'(in_arr[j - 1]));
            if (j < NRAND) begin
                logic [31:0]        r0;
                logic [31:0]        r1;
                logic signed [17:0] s0;
                logic signed [17:0] s1;
                logic [W-1:0]       p0;
                logic [W-1:0]       p1;
                logic [7:0]         a;
                logic [7:0]         nw;
                logic               pre;
                r0  = $urandom;
                r1  = $urandom;
                s0  = r0[17:0];
                s1  = r1[17:0];
                p0  = W'(s0);
                p1  = W'(s1);
                a   = 8'($urandom);
                nw  = 8'($urandom);
                pre = ($urandom_range(0, 7) == 0);
                exp_arr[j] = ref_sum(m_w, a, p0, p1);
                in_arr[j]  = a;
                if (pre) m_w = nw;
                drive(pre, nw, a, p0, p1);
            end else begin
                drive(1'b0, 8'd0, 8'd0, '0, '0);
            end
            tick();
        end
        chk("rand_final_weightO", 32'(bus.weightO), 32'(m_w));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
